// File: rtl/hdmi_period_sequencer.sv
// hdmi_period_sequencer: raster counters, sync levels and HDMI period schedule for the TMDS channels
module hdmi_period_sequencer #(
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int HSYNC_START   = 656,
  parameter int HSYNC_SIZE    = 96,
  parameter int VSYNC_START   = 490,
  parameter int VSYNC_SIZE    = 2,
  parameter int INVERT_SYNC   = 1,
  parameter int DI_START      = 650,
  parameter int MAX_PACKETS   = 18
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        packet_pending,
  output logic [11:0] cx,
  output logic [10:0] cy,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  mode,
  output logic [3:0]  ctl,
  output logic        packet_load,
  output logic [4:0]  di_counter
);
  typedef enum logic [2:0] {CTRL, VPRE, VGB, VIDEO, DPRE, DLGB, DDATA, DTGB} state_t;
  localparam logic [11:0] FW1 = 12'(FRAME_WIDTH - 1);
  localparam logic [10:0] FH1 = 11'(FRAME_HEIGHT - 1);
  localparam logic [11:0] SW  = 12'(SCREEN_WIDTH);
  localparam logic [10:0] SH  = 11'(SCREEN_HEIGHT);
  localparam logic [11:0] HS0 = 12'(HSYNC_START);
  localparam logic [11:0] HS1 = 12'(HSYNC_START + HSYNC_SIZE);
  localparam logic [10:0] VS0 = 11'(VSYNC_START);
  localparam logic [10:0] VS1 = 11'(VSYNC_START + VSYNC_SIZE);
  localparam logic [11:0] VP0 = 12'(FRAME_WIDTH - 10);
  localparam logic [11:0] VG0 = 12'(FRAME_WIDTH - 2);
  localparam logic [11:0] DI  = 12'(DI_START);
  // last packet-end pixel from which another 32-pixel slot plus trailing guard still fits before the preamble
  localparam logic [11:0] CONT_MAX = 12'(FRAME_WIDTH - 46);
  localparam logic [7:0]  NPK = 8'(MAX_PACKETS);
  localparam logic        DI_OK = (DI_START + 44 <= FRAME_WIDTH - 12) && (DI_START >= SCREEN_WIDTH);
  localparam logic        INV = (INVERT_SYNC != 0);
  state_t      r_state, w_state, w_vid;
  logic [11:0] r_cx, w_nx;
  logic [10:0] r_cy, w_ny, w_nl;
  logic [2:0]  r_cnt, w_cnt;
  logic [7:0]  r_npk, w_npk;
  logic [4:0]  r_di, w_di;
  logic [2:0]  r_mode, w_mode;
  logic [3:0]  r_ctl, w_ctl;
  logic        r_load, w_load, r_hs, r_vs, w_nla, w_cont;
  assign w_nx = (r_cx == FW1) ? '0 : r_cx + 12'd1;
  assign w_ny = (r_cx != FW1) ? r_cy : (r_cy == FH1) ? '0 : r_cy + 11'd1;
  assign w_nl = (w_ny == FH1) ? '0 : w_ny + 11'd1;
  assign w_nla = w_nl < SH;
  assign w_cont = packet_pending && (r_npk < NPK) && (w_nx <= CONT_MAX);
  assign w_vid = (w_nx < SW && w_ny < SH) ? VIDEO :
                 (w_nla && w_nx >= VG0) ? VGB :
                 (w_nla && w_nx >= VP0) ? VPRE : CTRL;
  assign w_mode = (w_state == VIDEO) ? 3'd1 : (w_state == VGB) ? 3'd2 : (w_state == DDATA) ? 3'd3 :
                  (w_state == DLGB || w_state == DTGB) ? 3'd4 : 3'd0;
  assign w_ctl = (w_state == VPRE) ? 4'b0001 : (w_state == DPRE) ? 4'b0101 : 4'b0000;
  assign cx = r_cx;
  assign cy = r_cy;
  assign hsync = r_hs;
  assign vsync = r_vs;
  assign mode = r_mode;
  assign ctl = r_ctl;
  assign packet_load = r_load;
  assign di_counter = r_di;
  // next-pixel state: island phases advance on their counters, otherwise position picks the period
  always_comb begin
    w_state = r_state;
    w_cnt = '0;
    w_di = '0;
    w_load = 1'b0;
    w_npk = r_npk;
    case (r_state)
      DPRE: begin
        w_state = (r_cnt == 3'd7) ? DLGB : DPRE;
        w_cnt = r_cnt + 3'd1;
      end
      DLGB: begin
        w_state = (r_cnt == 3'd0) ? DLGB : DDATA;
        w_cnt = (r_cnt == 3'd0) ? 3'd1 : 3'd0;
        w_load = (r_cnt == 3'd0);
        w_npk = (r_cnt == 3'd0) ? 8'd1 : r_npk;
      end
      DDATA: begin
        w_state = (r_di != 5'd31 || r_load) ? DDATA : DTGB;
        w_di = r_di + 5'd1;
        w_load = (r_di == 5'd30) && w_cont;
        w_npk = ((r_di == 5'd30) && w_cont) ? r_npk + 8'd1 : r_npk;
      end
      DTGB: begin
        w_state = (r_cnt == 3'd1) ? w_vid : DTGB;
        w_cnt = (r_cnt == 3'd1) ? 3'd0 : r_cnt + 3'd1;
      end
      default: w_state = (DI_OK && w_nx == DI && packet_pending) ? DPRE : w_vid;
    endcase
  end
  // every output register is loaded together so all of them describe the same pixel
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      r_cx <= '0;
      r_cy <= SH;
      r_state <= CTRL;
      r_cnt <= '0;
      r_npk <= '0;
      r_di <= '0;
      r_mode <= '0;
      r_ctl <= '0;
      r_load <= 1'b0;
      r_hs <= INV;
      r_vs <= INV;
    end else begin
      r_cx <= w_nx;
      r_cy <= w_ny;
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_npk <= w_npk;
      r_di <= w_di;
      r_mode <= w_mode;
      r_ctl <= w_ctl;
      r_load <= w_load;
      r_hs <= (w_nx >= HS0 && w_nx < HS1) ^ INV;
      r_vs <= (w_ny >= VS0 && w_ny < VS1) ^ INV;
    end
endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// tb_hdmi_period_sequencer: directed checks of raster, sync, video periods and data islands
module tb_hdmi_period_sequencer;
  logic clk, reset_n, pending;
  logic [11:0] cx, m1_cx, iv_cx;
  logic [10:0] cy, m1_cy, iv_cy;
  logic hs, vs, m1_hs, m1_vs, iv_hs, iv_vs;
  logic [2:0] mode, m1_mode, iv_mode;
  logic [3:0] ctl, m1_ctl, iv_ctl;
  logic pl, m1_pl, iv_pl;
  logic [4:0] di, m1_di, iv_di;
  int tests = 0;
  int fails = 0;

  hdmi_period_sequencer #(.FRAME_WIDTH(160), .FRAME_HEIGHT(20), .SCREEN_WIDTH(40), .SCREEN_HEIGHT(10),
    .HSYNC_START(44), .HSYNC_SIZE(8), .VSYNC_START(12), .VSYNC_SIZE(2), .INVERT_SYNC(0),
    .DI_START(50), .MAX_PACKETS(18)) u_dut (
    .clk_pixel(clk), .reset_n(reset_n), .packet_pending(pending), .cx(cx), .cy(cy), .hsync(hs),
    .vsync(vs), .mode(mode), .ctl(ctl), .packet_load(pl), .di_counter(di));

  hdmi_period_sequencer #(.FRAME_WIDTH(160), .FRAME_HEIGHT(20), .SCREEN_WIDTH(40), .SCREEN_HEIGHT(10),
    .HSYNC_START(44), .HSYNC_SIZE(8), .VSYNC_START(12), .VSYNC_SIZE(2), .INVERT_SYNC(0),
    .DI_START(50), .MAX_PACKETS(1)) u_max1 (
    .clk_pixel(clk), .reset_n(reset_n), .packet_pending(pending), .cx(m1_cx), .cy(m1_cy), .hsync(m1_hs),
    .vsync(m1_vs), .mode(m1_mode), .ctl(m1_ctl), .packet_load(m1_pl), .di_counter(m1_di));

  hdmi_period_sequencer #(.FRAME_WIDTH(160), .FRAME_HEIGHT(20), .SCREEN_WIDTH(40), .SCREEN_HEIGHT(10),
    .HSYNC_START(44), .HSYNC_SIZE(8), .VSYNC_START(12), .VSYNC_SIZE(2), .INVERT_SYNC(1),
    .DI_START(50), .MAX_PACKETS(18)) u_inv (
    .clk_pixel(clk), .reset_n(reset_n), .packet_pending(pending), .cx(iv_cx), .cy(iv_cy), .hsync(iv_hs),
    .vsync(iv_vs), .mode(iv_mode), .ctl(iv_ctl), .packet_load(iv_pl), .di_counter(iv_di));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_pos(input int x, input int y);
    int n = 0;
    while (!(cx == 12'(x) && cy == 11'(y)) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 4000) begin
      fails++;
      $display("FAIL wait_pos: position (%0d,%0d) never reached, now at (%0d,%0d)", x, y, cx, cy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({cx, cy} !== {12'd0, 11'd10}) begin
      fails++;
      $display("FAIL reset_pos: got cx=%0d cy=%0d, want cx=0 cy=10", cx, cy);
    end
    tests++;
    if ({mode, ctl, pl, di} !== 13'd0) begin
      fails++;
      $display("FAIL reset_out: got mode=%0d ctl=%b load=%b di=%0d, want all 0", mode, ctl, pl, di);
    end
    tests++;
    if ({hs, vs, iv_hs, iv_vs} !== 4'b0011) begin
      fails++;
      $display("FAIL reset_sync: got hs=%b vs=%b inv_hs=%b inv_vs=%b, want 0 0 1 1", hs, vs, iv_hs, iv_vs);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({cx, cy} !== {12'd1, 11'd10}) begin
      fails++;
      $display("FAIL reset_first_step: got cx=%0d cy=%0d, want cx=1 cy=10", cx, cy);
    end
  endtask

  task automatic test_video();
    logic [2:0] em;
    logic [3:0] ec;
    wait_pos(150, 19);
    for (int x = 150; x < 160; x++) begin
      em = (x < 158) ? 3'd0 : 3'd2;
      ec = (x < 158) ? 4'b0001 : 4'b0000;
      tests++;
      if ({cx, mode, ctl} !== {12'(x), em, ec}) begin
        fails++;
        $display("FAIL video_pre: cx=%0d got mode=%0d ctl=%b, want cx=%0d mode=%0d ctl=%b", cx, mode, ctl, x, em, ec);
      end
      @(negedge clk);
    end
    for (int x = 0; x <= 40; x++) begin
      em = (x < 40) ? 3'd1 : 3'd0;
      tests++;
      if ({cx, cy, mode, ctl} !== {12'(x), 11'd0, em, 4'd0}) begin
        fails++;
        $display("FAIL video_active: got cx=%0d cy=%0d mode=%0d ctl=%b, want cx=%0d cy=0 mode=%0d ctl=0000", cx, cy, mode, ctl, x, em);
      end
      @(negedge clk);
    end
    wait_pos(0, 9);
    for (int x = 0; x < 160; x++) begin
      em = (x < 40) ? 3'd1 : 3'd0;
      tests++;
      if ({cx, mode, ctl} !== {12'(x), em, 4'd0}) begin
        fails++;
        $display("FAIL video_last_line: cx=%0d got mode=%0d ctl=%b, want cx=%0d mode=%0d ctl=0000", cx, mode, ctl, x, em);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    logic [2:0] em;
    logic [3:0] ec;
    logic ep;
    logic [4:0] ed;
    wait_pos(48, 1);
    pending = 1'b1;
    @(negedge clk);
    for (int x = 49; x <= 95; x++) begin
      em = (x < 58) ? 3'd0 : (x < 60) ? 3'd4 : (x < 92) ? 3'd3 : (x < 94) ? 3'd4 : 3'd0;
      ec = (x >= 50 && x < 58) ? 4'b0101 : 4'b0000;
      ep = (x == 59);
      ed = (x >= 60 && x < 92) ? 5'(x - 60) : 5'd0;
      tests++;
      if ({cx, mode, ctl, pl, di} !== {12'(x), em, ec, ep, ed}) begin
        fails++;
        $display("FAIL single_packet: got cx=%0d mode=%0d ctl=%b load=%b di=%0d, want cx=%0d mode=%0d ctl=%b load=%b di=%0d",
                 cx, mode, ctl, pl, di, x, em, ec, ep, ed);
      end
      if (x == 59) pending = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_room();
    logic [2:0] em, em1;
    logic [3:0] ec;
    logic ep, ep1;
    logic [4:0] ed, ed1;
    wait_pos(48, 2);
    pending = 1'b1;
    wait_pos(50, 2);
    for (int x = 50; x < 160; x++) begin
      em = (x < 58) ? 3'd0 : (x < 60) ? 3'd4 : (x < 124) ? 3'd3 : (x < 126) ? 3'd4 : (x >= 158) ? 3'd2 : 3'd0;
      em1 = (x < 58) ? 3'd0 : (x < 60) ? 3'd4 : (x < 92) ? 3'd3 : (x < 94) ? 3'd4 : (x >= 158) ? 3'd2 : 3'd0;
      ec = (x < 58) ? 4'b0101 : (x >= 150 && x < 158) ? 4'b0001 : 4'b0000;
      ep = (x == 59) || (x == 91);
      ep1 = (x == 59);
      ed = (x >= 60 && x < 124) ? 5'((x - 60) % 32) : 5'd0;
      ed1 = (x >= 60 && x < 92) ? 5'(x - 60) : 5'd0;
      tests++;
      if ({cx, mode, ctl, pl, di} !== {12'(x), em, ec, ep, ed}) begin
        fails++;
        $display("FAIL room_limit: got cx=%0d mode=%0d ctl=%b load=%b di=%0d, want cx=%0d mode=%0d ctl=%b load=%b di=%0d",
                 cx, mode, ctl, pl, di, x, em, ec, ep, ed);
      end
      tests++;
      if ({iv_mode, iv_ctl, iv_pl, iv_di} !== {em, ec, ep, ed}) begin
        fails++;
        $display("FAIL room_limit_inv: cx=%0d got mode=%0d ctl=%b load=%b di=%0d, want mode=%0d ctl=%b load=%b di=%0d",
                 x, iv_mode, iv_ctl, iv_pl, iv_di, em, ec, ep, ed);
      end
      tests++;
      if ({m1_mode, m1_ctl, m1_pl, m1_di} !== {em1, ec, ep1, ed1}) begin
        fails++;
        $display("FAIL max_packets_1: cx=%0d got mode=%0d ctl=%b load=%b di=%0d, want mode=%0d ctl=%b load=%b di=%0d",
                 x, m1_mode, m1_ctl, m1_pl, m1_di, em1, ec, ep1, ed1);
      end
      if (x == 130) pending = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_sync();
    logic ehs, evs;
    wait_pos(0, 0);
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 160; x++) begin
        ehs = (x >= 44 && x < 52);
        evs = (y >= 12 && y < 14);
        tests++;
        if ({cx, cy, hs, vs} !== {12'(x), 11'(y), ehs, evs}) begin
          fails++;
          if (fails < 50) $display("FAIL sync: got cx=%0d cy=%0d hs=%b vs=%b, want cx=%0d cy=%0d hs=%b vs=%b", cx, cy, hs, vs, x, y, ehs, evs);
        end
        tests++;
        if ({iv_cx, iv_cy, iv_hs, iv_vs} !== {12'(x), 11'(y), ~ehs, ~evs}) begin
          fails++;
          if (fails < 50) $display("FAIL sync_inv: got cx=%0d cy=%0d hs=%b vs=%b, want cx=%0d cy=%0d hs=%b vs=%b", iv_cx, iv_cy, iv_hs, iv_vs, x, y, ~ehs, ~evs);
        end
        tests++;
        if ({m1_cx, m1_cy, m1_hs, m1_vs} !== {12'(x), 11'(y), ehs, evs}) begin
          fails++;
          if (fails < 50) $display("FAIL sync_max1: got cx=%0d cy=%0d hs=%b vs=%b, want cx=%0d cy=%0d hs=%b vs=%b", m1_cx, m1_cy, m1_hs, m1_vs, x, y, ehs, evs);
        end
        @(negedge clk);
      end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ec;
    wait_pos(48, 4);
    pending = 1'b1;
    wait_pos(70, 4);
    tests++;
    if ({mode, di} !== {3'd3, 5'd10}) begin
      fails++;
      $display("FAIL mid_island_setup: got mode=%0d di=%0d, want mode=3 di=10", mode, di);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({cx, cy, mode, ctl, pl, di, hs, vs} !== {12'd0, 11'd10, 13'd0, 2'b00}) begin
      fails++;
      $display("FAIL async_reset: got cx=%0d cy=%0d mode=%0d ctl=%b load=%b di=%0d hs=%b vs=%b, want 0 10 0 0000 0 0 0 0",
               cx, cy, mode, ctl, pl, di, hs, vs);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int x = 0; x <= 50; x++) begin
      ec = (x == 50) ? 4'b0101 : 4'b0000;
      tests++;
      if ({cx, cy, mode, ctl, pl} !== {12'(x), 11'd10, 3'd0, ec, 1'b0}) begin
        fails++;
        $display("FAIL post_reset: got cx=%0d cy=%0d mode=%0d ctl=%b load=%b, want cx=%0d cy=10 mode=0 ctl=%b load=0",
                 cx, cy, mode, ctl, pl, x, ec);
      end
      @(negedge clk);
    end
    pending = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    pending = 1'b0;
    #1 reset_n = 1'b0;
    test_reset();
    test_video();
    test_single();
    test_room();
    test_sync();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
